// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the control unit.
// Holds the status encodings seen by the control unit, the fetch FSM state
// type, the width defaults, and a helper that maps an FSM state to its status.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 16;
  localparam int unsigned STATUS_W    = 2;

  typedef enum logic [1:0] {
    STATUS_IDLE  = 2'd0,
    STATUS_FETCH = 2'd1,
    STATUS_READY = 2'd2,
    STATUS_DONE  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_READY = 3'd3,
    S_DONE  = 3'd4
  } fetch_state_e;

  // REQ and WAIT both report FETCH to the control unit.
  function automatic status_e status_of(input fetch_state_e st);
    status_e s;
    s = STATUS_IDLE;
    case (st)
      S_IDLE:  s = STATUS_IDLE;
      S_REQ:   s = STATUS_FETCH;
      S_WAIT:  s = STATUS_FETCH;
      S_READY: s = STATUS_READY;
      S_DONE:  s = STATUS_DONE;
      default: s = STATUS_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register.
// Ports:
//   i_clk, i_rstn  clock, synchronous active-low reset
//   i_clr          synchronous clear to 0
//   i_load         load i_load_val (wins over i_inc)
//   i_inc          increment modulo 2^ADDR_W
//   i_load_val     jump target
//   o_pc           current counter value
module pc_reg #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_load_val,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Clear, then load, then increment; the add wraps naturally at the width.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter and instruction register,
// issues single-cycle reads to instruction memory and reports progress to
// the control unit through a 2-bit status.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   start                     begin execution at address 0 (from IDLE/DONE)
//   ir_load                   fetch request (honoured in READY)
//   pc_inc, pc_load           PC increment / jump strobes (honoured in READY)
//   jump_cond, Z              conditional jump taken only when Z=0
//   finish                    end of program (READY -> DONE, beats ir_load)
//   imem_rdata                memory data, valid one cycle after imem_en
//   imem_en, imem_addr        memory read request, address = pc
//   instruction               instruction register
//   status                    0 IDLE, 1 FETCH, 2 READY, 3 DONE
//   pc                        program counter
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                ir_load,
  input  logic                pc_inc,
  input  logic                pc_load,
  input  logic                jump_cond,
  input  logic                Z,
  input  logic                finish,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                imem_en,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  instruction,
  output logic [STATUS_W-1:0] status,
  output logic [ADDR_W-1:0]   pc
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_imem_en;
  status_e             r_status;
  logic [ADDR_W-1:0]   w_pc;

  logic                w_imem_en_nxt;
  status_e             w_status_nxt;
  logic                w_start_ok;
  logic                w_jump_taken;
  logic                w_pc_clr;
  logic                w_pc_load;
  logic                w_pc_inc;
  logic                w_ir_clr;
  logic                w_ir_cap;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_READY;
      S_READY: begin
        if (finish) begin
          w_state_nxt = S_DONE;
        end else if (ir_load) begin
          w_state_nxt = S_REQ;
        end
      end
      S_DONE:  if (start) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath control. imem_en and status are computed from the next
  // state so that their registered copies line up with r_state.
  always_comb begin
    w_imem_en_nxt = 1'b0;
    w_status_nxt  = STATUS_IDLE;
    w_start_ok    = 1'b0;
    w_jump_taken  = 1'b0;
    w_pc_clr      = 1'b0;
    w_pc_load     = 1'b0;
    w_pc_inc      = 1'b0;
    w_ir_clr      = 1'b0;
    w_ir_cap      = 1'b0;

    w_imem_en_nxt = (w_state_nxt == S_REQ);
    w_status_nxt  = status_of(w_state_nxt);

    w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_pc_clr      = w_start_ok;
    w_ir_clr      = w_start_ok;
    w_ir_cap      = (r_state == S_WAIT);

    // An untaken conditional jump falls through to the increment.
    w_jump_taken  = pc_load && (!jump_cond || !Z);
    if (r_state == S_READY) begin
      w_pc_load = w_jump_taken;
      w_pc_inc  = pc_inc && !w_jump_taken;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_imem_en <= 1'b0;
      r_status  <= STATUS_IDLE;
    end else begin
      r_imem_en <= w_imem_en_nxt;
      r_status  <= w_status_nxt;
    end
  end

  // Instruction register; memory data lands while in WAIT.
  always_ff @(posedge clk) begin
    if (!rstn || w_ir_clr) begin
      r_ir <= '0;
    end else if (w_ir_cap) begin
      r_ir <= imem_rdata;
    end
  end

  pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_clr      (w_pc_clr),
    .i_load     (w_pc_load),
    .i_inc      (w_pc_inc),
    .i_load_val (r_ir[ADDR_W-1:0]),
    .o_pc       (w_pc)
  );

  assign imem_en     = r_imem_en;
  assign imem_addr   = w_pc;
  assign pc          = w_pc;
  assign instruction = r_ir;
  assign status      = r_status;

endmodule
